medio_sumador: RTL and testbench

Registered, lane-parallel half adder. Each of WIDTH independent lanes computes Suma = A xor B and Carry = A and B, with no carry propagation between lanes. A valid/ready handshake and one output register give it a 1-cycle latency. It is a leaf arithmetic block, used as the building element for full adders and ripple adders in the datapath.

---
 rtl/medio_sumador_if.sv | 31 +++
 rtl/medio_sumador_cell.sv | 16 +
 rtl/medio_sumador.sv | 57 +++++
 tb/tb_medio_sumador.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/medio_sumador_if.sv
`default_nettype none
// ============================================================================
//  Module      : medio_sumador_if
//  Description : Operand/result handshake bundle for the lane-parallel half
//                adder. The master drives the operands and accepts results.
//                The slave (the adder) returns ready and the registered results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface medio_sumador_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Suma;
  logic [WIDTH-1:0] Carry;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, B, in_valid, out_ready,
    input  in_ready, Suma, Carry, out_valid
  );

  modport slave (
    input  A, B, in_valid, out_ready,
    output in_ready, Suma, Carry, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/medio_sumador_cell.sv
`default_nettype none
// ============================================================================
//  Module      : half_adder_cell
//  Description : Purely combinational 1-bit half adder (s = a ^ b, c = a & b).
//  Revision    : 1.0 - initial release
// ============================================================================
module half_adder_cell (
  input  wire logic i_a,
  input  wire logic i_b,
  output logic      o_s,
  output logic      o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule
`default_nettype wire

// File: rtl/medio_sumador.sv
`default_nettype none
// ============================================================================
//  Module      : medio_sumador
//  Description : Registered, lane-parallel half adder with a valid/ready
//                handshake. WIDTH independent lanes, no carry between lanes,
//                one output register giving a latency of exactly one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module medio_sumador #(
  parameter int WIDTH = 1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  medio_sumador_if.slave bus
);
  logic [WIDTH-1:0] w_suma;
  logic [WIDTH-1:0] w_carry;
  logic             w_accept;
  logic [WIDTH-1:0] r_suma;
  logic [WIDTH-1:0] r_carry;
  logic             r_valid;

  // One independent cell per lane; carries stay inside their own lane.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    half_adder_cell u_cell (
      .i_a (bus.A[gi]),
      .i_b (bus.B[gi]),
      .o_s (w_suma[gi]),
      .o_c (w_carry[gi])
    );
  end

  // Ready only depends on the output register state, never on in_valid.
  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Output register: load on accept, drop valid on drain, otherwise hold.
  // Operands are only sampled on accept, so X on idle inputs cannot leak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_suma  <= '0;
      r_carry <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_suma  <= w_suma;
      r_carry <= w_carry;
      r_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.Suma      = r_suma;
  assign bus.Carry     = r_carry;
  assign bus.out_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_medio_sumador.sv
`default_nettype none
// ============================================================================
//  Module      : tb_medio_sumador
//  Description : Directed self-checking bench for medio_sumador, one instance
//                at WIDTH=1 and one at WIDTH=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_medio_sumador;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  medio_sumador_if #(.WIDTH(1)) bus1 ();
  medio_sumador_if #(.WIDTH(4)) bus4 ();

  medio_sumador #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  medio_sumador #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic va [4];
    logic vb [4];
    logic es [4];
    logic ec [4];
    va = '{1'b0, 1'b1, 1'b0, 1'b1};
    vb = '{1'b0, 1'b0, 1'b1, 1'b1};
    es = '{1'b0, 1'b1, 1'b1, 1'b0};
    ec = '{1'b0, 1'b0, 1'b0, 1'b1};
    n_vec = 0;
    n_err = 0;

    rst_n          = 1'b0;
    bus1.A         = '0;
    bus1.B         = '0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    bus4.A         = '0;
    bus4.B         = '0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_suma",      bus1.Suma,      64'd0);
    chk("rst_carry",     bus1.Carry,     64'd0);
    chk("rst_out_valid", bus1.out_valid, 64'd0);
    chk("rst_in_ready",  bus1.in_ready,  64'd1);
    chk("rst_w4_valid",  bus4.out_valid, 64'd0);
    rst_n = 1'b1;

    // Exhaustive truth table, full throughput
    for (int i = 0; i < 4; i++) begin
      bus1.A        = va[i];
      bus1.B        = vb[i];
      bus1.in_valid = 1'b1;
      @(negedge clk);
      chk("tt_suma",  bus1.Suma,      {63'd0, es[i]});
      chk("tt_carry", bus1.Carry,     {63'd0, ec[i]});
      chk("tt_valid", bus1.out_valid, 64'd1);
    end

    // Asynchronous reset between edges
    bus1.A = 1'b1;
    bus1.B = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_suma", bus1.Suma, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_suma",  bus1.Suma,      64'd0);
    chk("async_rst_carry", bus1.Carry,     64'd0);
    chk("async_rst_valid", bus1.out_valid, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    bus1.A = 1'b1;
    bus1.B = 1'b1;
    @(negedge clk);
    chk("post_rst_suma",  bus1.Suma,      64'd0);
    chk("post_rst_carry", bus1.Carry,     64'd1);
    chk("post_rst_valid", bus1.out_valid, 64'd1);

    // Backpressure
    bus1.A = 1'b1;
    bus1.B = 1'b0;
    @(negedge clk);
    chk("bp_load_suma", bus1.Suma, 64'd1);
    bus1.out_ready = 1'b0;
    bus1.A         = 1'b1;
    bus1.B         = 1'b1;
    #1;
    chk("bp_in_ready", bus1.in_ready, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_suma",  bus1.Suma,      64'd1);
      chk("bp_hold_carry", bus1.Carry,     64'd0);
      chk("bp_hold_valid", bus1.out_valid, 64'd1);
      chk("bp_hold_ready", bus1.in_ready,  64'd0);
    end
    bus1.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus1.in_ready, 64'd1);
    @(negedge clk);
    chk("bp_next_suma",  bus1.Suma,      64'd0);
    chk("bp_next_carry", bus1.Carry,     64'd1);
    chk("bp_next_valid", bus1.out_valid, 64'd1);

    // Bubbles, with X on idle operands
    bus1.A = 1'b0;
    bus1.B = 1'b1;
    @(negedge clk);
    chk("bub1_valid", bus1.out_valid, 64'd1);
    chk("bub1_suma",  bus1.Suma,      64'd1);
    bus1.in_valid = 1'b0;
    bus1.A        = 1'bx;
    bus1.B        = 1'bx;
    @(negedge clk);
    chk("bub0_valid", bus1.out_valid, 64'd0);
    chk("bub0_suma",  bus1.Suma,      64'd1);
    chk("bub0_carry", bus1.Carry,     64'd0);
    bus1.in_valid = 1'b1;
    bus1.A        = 1'b1;
    bus1.B        = 1'b1;
    @(negedge clk);
    chk("bub2_valid", bus1.out_valid, 64'd1);
    chk("bub2_suma",  bus1.Suma,      64'd0);
    chk("bub2_carry", bus1.Carry,     64'd1);
    bus1.in_valid = 1'b0;
    bus1.A        = 1'bx;
    bus1.B        = 1'bx;
    @(negedge clk);
    chk("idle_x_valid", bus1.out_valid, 64'd0);
    chk("idle_x_suma",  bus1.Suma,      64'd0);
    chk("idle_x_carry", bus1.Carry,     64'd1);
    @(negedge clk);
    chk("idle_hold_valid", bus1.out_valid, 64'd0);

    // WIDTH=4: independent lanes
    bus4.A        = 4'b1010;
    bus4.B        = 4'b0110;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    chk("w4_suma_a",  bus4.Suma,      64'hC);
    chk("w4_carry_a", bus4.Carry,     64'h2);
    chk("w4_valid_a", bus4.out_valid, 64'd1);
    bus4.A = 4'hF;
    bus4.B = 4'hF;
    @(negedge clk);
    chk("w4_suma_f",  bus4.Suma,  64'h0);
    chk("w4_carry_f", bus4.Carry, 64'hF);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    chk("w4_drain_valid", bus4.out_valid, 64'd0);
    chk("w4_drain_carry", bus4.Carry,     64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
